score_display: RTL and testbench



---
 rtl/score_display.sv | 199 +++++++++++++++++++
 tb/tb_score_display.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display
//   Shows the game FSM's binary score on a 4-digit, active-low, multiplexed
//   seven-segment display. A new score is converted to two BCD digits by a
//   sequential double-dabble engine (one shift per clock). Slot 0 shows the
//   ones digit and slot 1 shows the tens digit, with leading-zero blanking.
//   Slots 2 and 3 are always blank. Once the final score is reached, the
//   whole display blinks.
//
// Ports
//   clk      : system clock
//   reset    : synchronous, active-high
//   score_in : binary score from the game FSM
//   seg      : segment cathodes, active-low, bit0=a .. bit6=g
//   an       : digit anodes, active-low, an[0] = rightmost digit
//   dp       : decimal point, active-low, tied off (1)
//   busy     : high while a BCD conversion is in progress
module score_display #(
  parameter int unsigned SCORE_W     = 6,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned WIN_SCORE   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_in,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic               dp,
  output logic               busy
);

  // Shift register layout: {tens[3:0], ones[3:0], binary[SCORE_W-1:0]}
  localparam int unsigned SR_W  = SCORE_W + 8;
  localparam int unsigned IT_W  = $clog2(SCORE_W + 1);
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] conv_bin_q, conv_bin_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [SR_W-1:0]    sr_adj, sr_shift;
  logic [IT_W-1:0]    iter_q, iter_d;
  logic [3:0]         tens_q, tens_d, ones_q, ones_d;
  logic               busy_q, busy_d;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [1:0]         dsel_q, dsel_d;
  logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               phase_q, phase_d;
  logic               blink_act;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // One double-dabble step: add 3 to any nibble >= 5, then shift left.
  always_comb begin
    sr_adj = sr_q;
    if (sr_q[SR_W-1 -: 4] >= 4'd5) sr_adj[SR_W-1 -: 4] = sr_q[SR_W-1 -: 4] + 4'd3;
    if (sr_q[SR_W-5 -: 4] >= 4'd5) sr_adj[SR_W-5 -: 4] = sr_q[SR_W-5 -: 4] + 4'd3;
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Conversion FSM. A score change arriving mid-conversion is picked up on
  // return to IDLE, so the digits always converge to the latest score.
  always_comb begin
    state_d    = state_q;
    conv_bin_d = conv_bin_q;
    sr_d       = sr_q;
    iter_d     = iter_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (score_q != conv_bin_q) begin
          conv_bin_d = score_q;
          sr_d       = {8'b0, score_q};
          iter_d     = '0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        sr_d   = sr_shift;
        iter_d = iter_q + 1'b1;
        if (iter_q == IT_W'(SCORE_W - 1)) begin
          tens_d  = sr_shift[SR_W-1 -: 4];
          ones_d  = sr_shift[SR_W-5 -: 4];
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan counter and blink timer
  always_comb begin
    if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      dsel_d    = dsel_q + 2'd1;
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
      dsel_d    = dsel_q;
    end

    blink_act = (state_q == IDLE) && (conv_bin_q == SCORE_W'(WIN_SCORE));
    if (!blink_act) begin
      blk_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
      phase_d   = phase_q;
    end
  end

  // Digit mapping; registered, so seg/an lag the digit select by one cycle
  always_comb begin
    seg_d = 7'h7F;
    an_d  = 4'hF;
    case (dsel_q)
      2'd0: begin
        seg_d = seg_code(ones_q);
        an_d  = 4'b1110;
      end
      2'd1: begin
        if (tens_q != 4'd0) begin
          seg_d = seg_code(tens_q);
          an_d  = 4'b1101;
        end
      end
      default: ;
    endcase
    if (phase_q) an_d = 4'hF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      score_q    <= '0;
      conv_bin_q <= '0;
      sr_q       <= '0;
      iter_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      busy_q     <= 1'b0;
      ref_cnt_q  <= '0;
      dsel_q     <= '0;
      blk_cnt_q  <= '0;
      phase_q    <= 1'b0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
    end else begin
      state_q    <= state_d;
      score_q    <= score_in;
      conv_bin_q <= conv_bin_d;
      sr_q       <= sr_d;
      iter_q     <= iter_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      busy_q     <= busy_d;
      ref_cnt_q  <= ref_cnt_d;
      dsel_q     <= dsel_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;
  assign busy = busy_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int SW   = 6;
  localparam int REF  = 4;
  localparam int BLK  = 8;
  localparam int WIN  = 32;
  localparam int CONV_EDGES = SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] score_in;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          dp;
  logic          busy;

  int errors = 0;
  int checks = 0;

  score_display #(
    .SCORE_W(SW),
    .REFRESH_DIV(REF),
    .BLINK_DIV(BLK),
    .WIN_SCORE(WIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .score_in(score_in),
    .seg(seg),
    .an(an),
    .dp(dp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edge-count arithmetic for scan and blink, plain
  // division for the digits, and a countdown for conversion latency.
  int         m_score, m_conv_bin, m_left, m_tens, m_ones, m_n, m_blink_n;
  int         m_slot;
  bit         m_ph, m_blink_on, m_valid = 1'b0;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_busy;

  always @(posedge clk) begin
    if (reset) begin
      m_score = 0; m_conv_bin = 0; m_left = 0; m_tens = 0; m_ones = 0;
      m_n = 0; m_blink_n = 0;
      exp_seg = 7'h7F; exp_an = 4'hF; exp_busy = 1'b0;
    end else begin
      // outputs reflect the state held before this edge
      m_slot  = (m_n / REF) % 4;
      m_ph    = ((m_blink_n / BLK) % 2) == 1;
      exp_seg = 7'h7F;
      exp_an  = 4'hF;
      if (m_slot == 0) begin
        exp_seg = segs[m_ones];
        exp_an  = 4'b1110;
      end else if (m_slot == 1 && m_tens != 0) begin
        exp_seg = segs[m_tens];
        exp_an  = 4'b1101;
      end
      if (m_ph) exp_an = 4'hF;

      m_blink_on = (m_left == 0) && (m_conv_bin == WIN);
      m_blink_n  = m_blink_on ? m_blink_n + 1 : 0;

      if (m_left == 0) begin
        if (m_score != m_conv_bin) begin
          m_conv_bin = m_score;
          m_left     = CONV_EDGES;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_tens = m_conv_bin / 10;
          m_ones = m_conv_bin % 10;
        end
      end
      exp_busy = (m_left != 0);
      m_n++;
      m_score = int'(score_in);
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("seg", 16'(seg), 16'(exp_seg));
      chk("an", 16'(an), 16'(exp_an));
      chk("busy", 16'(busy), 16'(exp_busy));
      chk("dp", 16'(dp), 16'd1);
    end
  end

  task automatic wait_an(input logic [3:0] target, input logic [6:0] seg_exp, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (an === target) found = 1'b1;
    end
    if (!found) chk({name, "_timeout"}, 16'd0, 16'd1);
    else        chk(name, 16'(seg), 16'(seg_exp));
  endtask

  int bcnt, first;

  initial begin
    reset    = 1'b1;
    score_in = '0;
    repeat (3) @(negedge clk);
    chk("t1_rst_seg", 16'(seg), 16'h7F);
    chk("t1_rst_an", 16'(an), 16'hF);
    chk("t1_rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;

    // 1: idle at zero, no conversion
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("t1_busy_cnt", 16'(bcnt), 16'd0);
    wait_an(4'b1110, 7'h40, "t1_slot0");

    // 2: 27, busy for 6 cycles starting one edge after sampling
    score_in = 6'd27;
    bcnt = 0; first = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) begin
        bcnt++;
        if (first < 0) first = i;
      end
    end
    chk("t2_busy_cnt", 16'(bcnt), 16'd6);
    chk("t2_busy_start", 16'(first), 16'd2);
    wait_an(4'b1110, 7'h78, "t2_ones");
    wait_an(4'b1101, 7'h24, "t2_tens");

    // 3: 5, tens blanked
    score_in = 6'd5;
    repeat (12) @(negedge clk);
    wait_an(4'b1110, 7'h12, "t3_ones");
    bcnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an == 4'b1101) bcnt++;
    end
    chk("t3_tens_blank", 16'(bcnt), 16'd0);

    // 4: 10 then 13 mid-conversion, back-to-back conversions
    score_in = 6'd10;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) score_in = 6'd13;
      if (busy) bcnt++;
    end
    chk("t4_busy_cnt", 16'(bcnt), 16'd12);
    wait_an(4'b1110, 7'h30, "t4_ones");
    wait_an(4'b1101, 7'h79, "t4_tens");
    chk("t4_busy_end", 16'(busy), 16'd0);

    // 5: 32 blinks, 31 stops blinking
    score_in = 6'd32;
    repeat (20 + 64) @(negedge clk);
    score_in = 6'd31;
    repeat (20) @(negedge clk);
    wait_an(4'b1110, 7'h79, "t5_ones");
    wait_an(4'b1101, 7'h30, "t5_tens");

    // 6: reset three cycles into converting 45
    score_in = 6'd45;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 16'(busy), 16'd0);
    chk("t6_rst_seg", 16'(seg), 16'h7F);
    chk("t6_rst_an", 16'(an), 16'hF);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_zero_seg", 16'(seg), 16'h40);
    chk("t6_zero_an", 16'(an), 16'hE);
    repeat (12) @(negedge clk);
    wait_an(4'b1110, 7'h12, "t6_ones");
    wait_an(4'b1101, 7'h19, "t6_tens");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
